// File: rtl/ctxt_pkg.sv
// Shared definitions for the context-packet scheduler: FSM states, source
// indices, default message codes and a saturating counter helper.
package ctxt_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StGap  = 2'd2
  } state_e;

  localparam int unsigned SRC_UNDERRUN = 0;
  localparam int unsigned SRC_SEQERR   = 1;
  localparam int unsigned SRC_LATE     = 2;
  localparam int unsigned SRC_ACK      = 3;
  localparam int unsigned SRC_FC       = 4;

  localparam logic [31:0] MSG_NONE       = 32'h0000_0000;
  localparam logic [31:0] FC_MSG_DEFAULT = 32'h0000_0100;

  // Add a small increment to a 16-bit counter, pinning at all-ones.
  function automatic logic [15:0] sat_add16(logic [15:0] a, logic [2:0] b);
    logic [16:0] sum;
    sum = {1'b0, a} + 17'(b);
    return sum[16] ? 16'hFFFF : sum[15:0];
  endfunction

endpackage

// File: rtl/ctxt_fc_tracker.sv
// Flow-control report source: tracks how far seqnum has moved since the last
// report and how long ago that was, and raises a pending request.
module ctxt_fc_tracker
  import ctxt_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic [31:0] seqnum,
  input  logic [15:0] fc_interval,
  input  logic [31:0] fc_timeout,
  input  logic        fc_grant,
  output logic        fc_req
);

  logic [31:0] last_rep;
  logic [31:0] fc_timer;
  logic [31:0] delta;
  logic        hit_interval;
  logic        hit_timeout;

  // Modulo-2^32 distance keeps the trigger correct across seqnum wrap.
  always_comb begin
    delta        = seqnum - last_rep;
    hit_interval = (fc_interval != 16'h0) && (delta >= {16'h0, fc_interval});
    hit_timeout  = (fc_timeout != 32'h0) && (fc_timer >= fc_timeout) && (delta != 32'h0);
  end

  // Report bookkeeping: grant re-bases on the current seqnum and restarts the timer.
  always_ff @(posedge clk) begin
    if (reset) begin
      last_rep <= 32'h0;
      fc_timer <= 32'h0;
      fc_req   <= 1'b0;
    end else if (clear) begin
      last_rep <= seqnum;
      fc_timer <= 32'h0;
      fc_req   <= 1'b0;
    end else if (fc_grant) begin
      last_rep <= seqnum;
      fc_timer <= 32'h0;
      fc_req   <= 1'b0;
    end else begin
      if (fc_timer != 32'hFFFF_FFFF) fc_timer <= fc_timer + 32'h1;
      if (hit_interval || hit_timeout) fc_req <= 1'b1;
    end
  end

endmodule

// File: rtl/ctxt_pkt_sched.sv
// Context-packet scheduler: captures event requests, arbitrates them with the
// FC report source, triggers the generator one packet at a time and enforces
// a hold-off gap after each completion.
module ctxt_pkt_sched
  import ctxt_pkg::*;
#(
  parameter int unsigned NUM_EV   = 4,
  parameter int unsigned HOLDOFF  = 8,
  parameter int unsigned WAIT_MAX = 1023,
  parameter logic [31:0] FC_MSG   = FC_MSG_DEFAULT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  enable,
  input  logic [NUM_EV-1:0]     ev_req,
  input  logic [32*NUM_EV-1:0]  ev_msg,
  input  logic [31:0]           seqnum,
  input  logic [15:0]           fc_interval,
  input  logic [31:0]           fc_timeout,
  output logic                  trigger,
  output logic [31:0]           message,
  input  logic                  sent,
  output logic                  busy,
  output logic [NUM_EV:0]       pend,
  output logic [15:0]           drop_cnt,
  output logic                  timeout_err
);

  localparam int unsigned NUM_SRC = NUM_EV + 1;
  localparam int unsigned WW = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
  localparam int unsigned GW = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;

  state_e              state;
  logic [NUM_EV-1:0]   ev_pend;
  logic [31:0]         ev_msg_q [NUM_EV];
  logic [WW-1:0]       wait_cnt;
  logic [GW-1:0]       gap_cnt;
  logic                fc_req;
  logic [NUM_SRC-1:0]  pend_all;
  logic [NUM_SRC-1:0]  grant;
  logic                grant_ok;
  logic [2:0]          n_drop;
  logic [31:0]         win_msg;

  ctxt_fc_tracker u_fc (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .seqnum      (seqnum),
    .fc_interval (fc_interval),
    .fc_timeout  (fc_timeout),
    .fc_grant    (grant[SRC_FC]),
    .fc_req      (fc_req)
  );

  assign pend_all = {fc_req, ev_pend};
  assign pend     = pend_all;
  assign busy     = (state != StIdle);

  // Fixed-priority pick (lowest index wins), winner's message and drop count.
  always_comb begin
    grant_ok = (state == StIdle) && enable && !clear && (|pend_all);
    grant    = '0;
    if (grant_ok) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (pend_all[i] && (grant == '0)) grant[i] = 1'b1;
      end
    end
    win_msg = FC_MSG;
    unique case (1'b1)
      grant[SRC_UNDERRUN]: win_msg = ev_msg_q[SRC_UNDERRUN];
      grant[SRC_SEQERR]:   win_msg = ev_msg_q[SRC_SEQERR];
      grant[SRC_LATE]:     win_msg = ev_msg_q[SRC_LATE];
      grant[SRC_ACK]:      win_msg = ev_msg_q[SRC_ACK];
      default:             win_msg = FC_MSG;
    endcase
    // A request on a source being granted this cycle re-arms it, so no drop.
    n_drop = 3'd0;
    for (int i = 0; i < NUM_EV; i++) begin
      if (ev_req[i] && ev_pend[i] && !grant[i]) n_drop = n_drop + 3'd1;
    end
  end

  // Event pending capture; clear overrides any same-cycle request.
  always_ff @(posedge clk) begin
    if (reset) begin
      ev_pend  <= '0;
      drop_cnt <= 16'h0;
      for (int i = 0; i < NUM_EV; i++) ev_msg_q[i] <= MSG_NONE;
    end else if (clear) begin
      ev_pend  <= '0;
      drop_cnt <= 16'h0;
    end else begin
      for (int i = 0; i < NUM_EV; i++) begin
        if (ev_req[i] && (!ev_pend[i] || grant[i])) begin
          ev_pend[i]  <= 1'b1;
          ev_msg_q[i] <= ev_msg[32*i +: 32];
        end else if (grant[i]) begin
          ev_pend[i] <= 1'b0;
        end
      end
      drop_cnt <= sat_add16(drop_cnt, n_drop);
    end
  end

  // Packet FSM: grant, wait for sent (or time out), then hold-off gap.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= StIdle;
      trigger     <= 1'b0;
      message     <= MSG_NONE;
      wait_cnt    <= '0;
      gap_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      trigger <= 1'b0;
      unique case (state)
        StIdle: begin
          if (grant_ok) begin
            trigger  <= 1'b1;
            message  <= win_msg;
            wait_cnt <= '0;
            state    <= StBusy;
          end
        end
        StBusy: begin
          wait_cnt <= wait_cnt + 1'b1;
          if (sent) begin
            gap_cnt <= GW'(HOLDOFF);
            state   <= (HOLDOFF == 0) ? StIdle : StGap;
          end else if (wait_cnt == WW'(WAIT_MAX)) begin
            timeout_err <= 1'b1;
            gap_cnt     <= GW'(HOLDOFF);
            state       <= StGap;
          end
        end
        StGap: begin
          if (gap_cnt == '0) state <= StIdle;
          else gap_cnt <= gap_cnt - 1'b1;
        end
        default: state <= StIdle;
      endcase
      // Clear drops status only; an in-flight packet still runs to completion.
      if (clear) timeout_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ctxt_pkt_sched.sv
// Scoreboard bench for ctxt_pkt_sched: stimulus pushes expected messages, a
// negedge monitor pops one per trigger and checks message hold between grants.
module tb_ctxt_pkt_sched;

  localparam int unsigned HOLDOFF  = 8;
  localparam int unsigned WAIT_MAX = 1023;
  localparam logic [31:0] FC_MSG   = 32'h0000_0100;

  logic         clk = 1'b0;
  logic         reset, clear, enable, sent;
  logic [3:0]   ev_req;
  logic [127:0] ev_msg;
  logic [31:0]  seqnum;
  logic [15:0]  fc_interval;
  logic [31:0]  fc_timeout;
  logic         trigger, busy, timeout_err;
  logic [31:0]  message;
  logic [4:0]   pend;
  logic [15:0]  drop_cnt;

  int total = 0;
  int bad   = 0;
  logic [31:0] sb [$];
  logic [31:0] last_msg = 32'h0;
  logic        have_last = 1'b0;

  ctxt_pkt_sched #(
    .NUM_EV   (4),
    .HOLDOFF  (HOLDOFF),
    .WAIT_MAX (WAIT_MAX),
    .FC_MSG   (FC_MSG)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .clear       (clear),
    .enable      (enable),
    .ev_req      (ev_req),
    .ev_msg      (ev_msg),
    .seqnum      (seqnum),
    .fc_interval (fc_interval),
    .fc_timeout  (fc_timeout),
    .trigger     (trigger),
    .message     (message),
    .sent        (sent),
    .busy        (busy),
    .pend        (pend),
    .drop_cnt    (drop_cnt),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_msg(input int i, input logic [31:0] m);
    ev_msg[32*i +: 32] = m;
  endtask

  // Cycles from now until trigger is seen (bounded).
  task automatic wait_trig(output int n);
    n = 0;
    while (!trigger && n < 2000) begin
      tick();
      n++;
    end
    if (!trigger) check("trigger_seen", 32'(trigger), 32'd1);
  endtask

  task automatic pulse_sent(input int delay);
    repeat (delay) tick();
    sent = 1'b1;
    tick();
    sent = 1'b0;
  endtask

  // Cycles until busy drops (bounded).
  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 2000) begin
      tick();
      n++;
    end
    if (busy) check("busy_drop", 32'(busy), 32'd0);
  endtask

  // Monitor: pop on every trigger, otherwise the message must hold.
  always @(negedge clk) begin
    if (!reset) begin
      if (trigger) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_trigger: got message %h, none expected", message);
        end else begin
          last_msg = sb.pop_front();
          have_last = 1'b1;
          check("trig_msg", message, last_msg);
        end
      end else if (have_last) begin
        check("msg_hold", message, last_msg);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset = 1'b1; clear = 1'b0; enable = 1'b0; sent = 1'b0;
    ev_req = '0; ev_msg = '0; seqnum = '0; fc_interval = '0; fc_timeout = '0;
    repeat (3) tick();
    check("rst_trigger", 32'(trigger), 32'd0);
    check("rst_message", message, 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_pend", 32'(pend), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    check("rst_timeout", 32'(timeout_err), 32'd0);
    reset = 1'b0;
    enable = 1'b1;
    tick();

    // Single event on source 1.
    set_msg(1, 32'hDEAD_0001);
    ev_req = 4'b0010;
    sb.push_back(32'hDEAD_0001);
    tick();
    ev_req = '0;
    check("single_pend", 32'(pend), 32'h02);
    wait_trig(n);
    check("single_latency", n, 1);
    check("single_pend_cleared", 32'(pend), 32'h00);
    pulse_sent(20);
    wait_idle(n);
    check("gap_len", n, HOLDOFF + 1);

    // Priority: src0 before src3, src3 after the gap.
    set_msg(0, 32'hA000_0000);
    set_msg(3, 32'hA300_0003);
    ev_req = 4'b1001;
    sb.push_back(32'hA000_0000);
    sb.push_back(32'hA300_0003);
    tick();
    ev_req = '0;
    wait_trig(n);
    check("prio_latency", n, 1);
    check("prio_pend", 32'(pend), 32'h08);
    pulse_sent(5);
    wait_idle(n);
    check("prio_gap", n, HOLDOFF + 1);
    wait_trig(n);
    check("prio_second", n, 1);
    pulse_sent(3);
    wait_idle(n);

    // Drop while pending, then a request coinciding with the grant.
    enable = 1'b0;
    set_msg(2, 32'hC200_0001);
    ev_req = 4'b0100;
    tick();
    set_msg(2, 32'hC200_0002);
    tick();
    ev_req = '0;
    check("drop_cnt1", 32'(drop_cnt), 32'd1);
    check("drop_pend", 32'(pend), 32'h04);
    enable = 1'b1;
    set_msg(2, 32'hC200_0004);
    ev_req = 4'b0100;
    sb.push_back(32'hC200_0001);
    sb.push_back(32'hC200_0004);
    tick();
    ev_req = '0;
    check("coin_trigger", 32'(trigger), 32'd1);
    check("coin_pend", 32'(pend), 32'h04);
    check("coin_drop", 32'(drop_cnt), 32'd1);
    pulse_sent(4);
    wait_idle(n);
    wait_trig(n);
    pulse_sent(2);
    wait_idle(n);

    // FC interval, then across the seqnum wrap.
    fc_interval = 16'd4;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_drop", 32'(drop_cnt), 32'd0);
    for (int s = 1; s <= 3; s++) begin
      seqnum = 32'(s);
      tick();
      tick();
      check("fc_early", 32'(pend), 32'h00);
    end
    seqnum = 32'd4;
    sb.push_back(FC_MSG);
    wait_trig(n);
    check("fc_int_latency", n, 2);
    pulse_sent(2);
    wait_idle(n);
    seqnum = 32'hFFFF_FFFE;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("fc_wrap_clear", 32'(pend), 32'h00);
    seqnum = 32'hFFFF_FFFF; tick(); tick();
    seqnum = 32'h0;         tick(); tick();
    seqnum = 32'h1;         tick(); tick();
    check("fc_wrap_early", 32'(pend), 32'h00);
    seqnum = 32'h2;
    sb.push_back(FC_MSG);
    wait_trig(n);
    check("fc_wrap_latency", n, 2);
    pulse_sent(2);
    wait_idle(n);
    fc_interval = 16'd0;

    // FC timeout: one step of seqnum reports after the timer expires.
    fc_timeout = 32'd100;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    seqnum = seqnum + 32'd1;
    sb.push_back(FC_MSG);
    wait_trig(n);
    check("fc_tmo_latency", n, 102);
    pulse_sent(2);
    wait_idle(n);
    repeat (300) tick();
    check("fc_tmo_quiet", 32'(pend), 32'h00);
    fc_timeout = 32'd0;

    // Generator never answers: timeout after WAIT_MAX.
    set_msg(0, 32'hE000_0000);
    ev_req = 4'b0001;
    sb.push_back(32'hE000_0000);
    tick();
    ev_req = '0;
    wait_trig(n);
    n = 0;
    while (!timeout_err && n < 1200) begin
      tick();
      n++;
    end
    check("timeout_cycles", n, WAIT_MAX + 1);
    check("timeout_busy", 32'(busy), 32'd1);
    wait_idle(n);

    // Clear during BUSY wipes status but the packet still completes.
    set_msg(0, 32'hE000_0001);
    ev_req = 4'b0001;
    sb.push_back(32'hE000_0001);
    tick();
    ev_req = '0;
    wait_trig(n);
    set_msg(1, 32'hE100_0001);
    ev_req = 4'b0010;
    tick();
    ev_req = '0;
    check("busy_pend", 32'(pend), 32'h02);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clr_pend", 32'(pend), 32'h00);
    check("clr_timeout", 32'(timeout_err), 32'd0);
    check("clr_busy", 32'(busy), 32'd1);
    pulse_sent(2);
    wait_idle(n);
    check("clr_gap", n, HOLDOFF + 1);
    repeat (20) tick();

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
